// File: rtl/bignum_msb_scan.sv
// bignum_msb_scan: multi-cycle leading-one detector for wide unsigned operands.
// Scans the captured operand from its most significant CHUNK-bit slice downward,
// one slice per clock, and stops at the first non-zero slice. It reports either
// floor(log2 a) or the bit length of a, together with an all-zero flag and a
// one-cycle completion pulse. All outputs come straight from flops.
module bignum_msb_scan #(
   parameter int NBITS = 2048,
   parameter int CHUNK = 64,
   parameter int YW    = $clog2(NBITS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_p,
   input  logic [NBITS-1:0] a,
   input  logic             mode,
   output logic [YW-1:0]    y,
   output logic             zero,
   output logic             busy,
   output logic             done_irq_p
);

   localparam int NCH = NBITS / CHUNK;
   localparam int IW  = $clog2(NCH);
   localparam int PW  = $clog2(CHUNK);
   localparam int LW  = IW + PW;

   typedef enum logic [0:0] {
      IDLE_ST = 1'b0,
      SCAN_ST = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [NBITS-1:0]   operand_r;
   logic [NBITS-1:0]   operand_s;
   logic               mode_r;
   logic               mode_s;
   logic [IW-1:0]      idx_r;
   logic [IW-1:0]      idx_s;
   logic [YW-1:0]      y_r;
   logic [YW-1:0]      y_s;
   logic               zero_r;
   logic               zero_s;
   logic               done_r;
   logic               done_s;
   logic [LW-1:0]      base_s;
   logic [CHUNK-1:0]   chunk_s;
   logic [PW-1:0]      pos_s;
   logic [YW-1:0]      r_s;

   // Priority encoder: index of the highest set bit (0 when the slice is empty;
   // the caller only uses it for non-zero slices).
   function automatic logic [PW-1:0] msb_pos(input logic [CHUNK-1:0] v);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (v[i]) begin
            p = PW'(i);
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

   // Slice selection and bit position: CHUNK is a power of two, so the
   // result idx*CHUNK + p is simply the concatenation {idx, p}.
   always_comb begin
      base_s  = {idx_r, {PW{1'b0}}};
      chunk_s = operand_r[base_s +: CHUNK];
      pos_s   = msb_pos(chunk_s);
      r_s     = YW'({idx_r, pos_s});
   end

   // Next-state and next-value logic for the IDLE/SCAN controller.
   always_comb begin
      state_s   = state_r;
      operand_s = operand_r;
      mode_s    = mode_r;
      idx_s     = idx_r;
      y_s       = y_r;
      zero_s    = zero_r;
      done_s    = 1'b0;
      case (state_r)
         IDLE_ST: begin
            if (enable_p) begin
               operand_s = a;
               mode_s    = mode;
               idx_s     = IW'(NCH - 1);
               state_s   = SCAN_ST;
            end else begin
               state_s   = IDLE_ST;
            end
         end
         SCAN_ST: begin
            // enable_p is deliberately not looked at here: starts are dropped
            // while a scan is in flight, including on the completion edge.
            if (chunk_s != {CHUNK{1'b0}}) begin
               y_s     = mode_r ? (r_s + YW'(1)) : r_s;
               zero_s  = 1'b0;
               done_s  = 1'b1;
               state_s = IDLE_ST;
            end else if (idx_r == {IW{1'b0}}) begin
               y_s     = {YW{1'b0}};
               zero_s  = 1'b1;
               done_s  = 1'b1;
               state_s = IDLE_ST;
            end else begin
               idx_s   = idx_r - IW'(1);
               state_s = SCAN_ST;
            end
         end
         default: begin
            state_s = IDLE_ST;
         end
      endcase
   end

   // State, operand, index and result registers; reset aborts any scan silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE_ST;
         operand_r <= {NBITS{1'b0}};
         mode_r    <= 1'b0;
         idx_r     <= {IW{1'b0}};
         y_r       <= {YW{1'b0}};
         zero_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         operand_r <= operand_s;
         mode_r    <= mode_s;
         idx_r     <= idx_s;
         y_r       <= y_s;
         zero_r    <= zero_s;
         done_r    <= done_s;
      end
   end

   assign y          = y_r;
   assign zero       = zero_r;
   assign busy       = (state_r == SCAN_ST);
   assign done_irq_p = done_r;

endmodule

// File: tb/tb_bignum_msb_scan.sv
// Self-checking bench for bignum_msb_scan: directed cases plus randomized
// operands, checked against a plain bit-scan reference model.
module tb_bignum_msb_scan;

   localparam int NBITS = 2048;
   localparam int CHUNK = 64;
   localparam int NCH   = NBITS / CHUNK;
   localparam int YW    = $clog2(NBITS) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable_p;
   logic [NBITS-1:0] a;
   logic             mode;
   logic [YW-1:0]    y;
   logic             zero;
   logic             busy;
   logic             done_irq_p;

   int               n_vec = 0;
   int               n_err = 0;
   logic [YW-1:0]    prev_y;
   logic             prev_zero;

   always #5 clk = ~clk;

   bignum_msb_scan #(.NBITS(NBITS), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable_p   (enable_p),
      .a          (a),
      .mode       (mode),
      .y          (y),
      .zero       (zero),
      .busy       (busy),
      .done_irq_p (done_irq_p)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: index of the most significant set bit, -1 for zero.
   function automatic int ref_msb(input logic [NBITS-1:0] v);
      for (int i = NBITS - 1; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NBITS-1:0] pow2(input int k);
      logic [NBITS-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // One operation; optionally pulses enable_p with operand alt after cycle inject_at.
   task automatic run_op(input logic [NBITS-1:0] op, input logic m,
                         input int inject_at, input logic [NBITS-1:0] alt);
      int            msb;
      int            exp_lat;
      int            cyc;
      int            busy_cnt;
      logic [YW-1:0] exp_y;
      logic          exp_zero;
      msb      = ref_msb(op);
      exp_zero = (msb < 0);
      exp_y    = exp_zero ? '0 : YW'(msb + (m ? 1 : 0));
      exp_lat  = exp_zero ? (NCH + 1) : (2 + (NCH - 1 - msb / CHUNK));

      @(negedge clk);
      enable_p = 1'b1;
      a        = op;
      mode     = m;
      @(posedge clk);
      #1;
      enable_p = 1'b0;
      a        = ~op;
      mode     = ~m;
      check_val("busy_at_start", busy, 1);
      check_val("done_at_start", done_irq_p, 0);
      check_val("y_held", y, prev_y);
      check_val("zero_held", zero, prev_zero);

      cyc      = 1;
      busy_cnt = 1;
      while (done_irq_p !== 1'b1 && cyc < NCH + 4) begin
         enable_p = (cyc == inject_at);
         if (cyc == inject_at) begin
            a    = alt;
            mode = $urandom_range(0, 1);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (busy === 1'b1) busy_cnt++;
      end
      enable_p = 1'b0;

      check_val("latency", cyc, exp_lat);
      check_val("busy_cycles", busy_cnt, exp_lat - 1);
      check_val("busy_at_done", busy, 0);
      check_val("y", y, exp_y);
      check_val("zero", zero, exp_zero);
      prev_y    = exp_y;
      prev_zero = exp_zero;
   endtask

   // Start a scan of a=1, assert reset after cycle 10, then release it.
   task automatic reset_mid();
      @(negedge clk);
      enable_p = 1'b1;
      a        = pow2(0);
      mode     = 1'b1;
      @(posedge clk);
      #1;
      enable_p = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("rst_y", y, 0);
      check_val("rst_zero", zero, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done_irq_p, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_val("rst_hold_done", done_irq_p, 0);
      end
      @(negedge clk);
      rst       = 1'b0;
      prev_y    = '0;
      prev_zero = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check_val("post_rst_done", done_irq_p, 0);
      end
   endtask

   initial begin
      logic [NBITS-1:0] op;
      logic [NBITS-1:0] alt;
      int               pos;
      int               inj;
      int               lat;

      rst      = 1'b1;
      enable_p = 1'b0;
      a        = '0;
      mode     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_y", y, 0);
      check_val("reset_zero", zero, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_done", done_irq_p, 0);
      @(negedge clk);
      rst       = 1'b0;
      prev_y    = '0;
      prev_zero = 1'b0;

      // Directed cases
      run_op(pow2(NBITS - 1), 1'b0, 0, '0);
      run_op(pow2(NBITS - 1), 1'b1, 0, '0);
      run_op(pow2(0), 1'b1, 0, '0);
      run_op(pow2(0), 1'b0, 0, '0);
      run_op('0, 1'b0, 0, '0);
      run_op('0, 1'b1, 0, '0);
      run_op(pow2(64) | pow2(63) | pow2(0), 1'b0, 0, '0);
      run_op(pow2(127), 1'b0, 0, '0);

      // Ignored mid-scan start, then back-to-back restart after done
      run_op(pow2(0), 1'b0, 4, pow2(NBITS - 1));
      run_op(pow2(NBITS - 1), 1'b0, 0, '0);

      // Reset during a scan, then a fresh operation
      reset_mid();
      run_op(pow2(1000), 1'b0, 0, '0);

      // Randomized operands, some with a start pulse while busy
      for (int t = 0; t < 40; t++) begin
         pos = $urandom_range(0, NBITS);
         op  = '0;
         if (pos < NBITS) begin
            op[pos] = 1'b1;
            for (int i = 0; i < pos; i++) op[i] = 1'($urandom_range(0, 1));
         end
         alt = '0;
         for (int i = 0; i < NBITS; i += 32) alt[i +: 32] = $urandom;
         lat = (pos >= NBITS) ? (NCH + 1) : (2 + (NCH - 1 - pos / CHUNK));
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat - 1)) : 0;
         run_op(op, 1'($urandom_range(0, 1)), inj, alt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
